// File: rtl/bpsk_pkg.sv
// Shared BPSK constants: sample format, carrier table and transmitter state encoding.
package bpsk_pkg;

  localparam int unsigned SIGNAL_WIDTH    = 10;
  localparam int unsigned WAVELENGTH      = 32;
  localparam int unsigned SINE_RESOLUTION = WAVELENGTH;
  localparam int unsigned AMPLITUDE       = 511;
  localparam int unsigned PHASE_W         = $clog2(WAVELENGTH);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} tx_state_t;

  // round(AMPLITUDE * (1 + sin(2*pi*k/SINE_RESOLUTION)))
  localparam logic [SIGNAL_WIDTH-1:0] SHIFTED_SINE_TABLE [SINE_RESOLUTION] = '{
    10'd511,  10'd611,  10'd707,  10'd795,  10'd872,  10'd936,  10'd983,  10'd1012,
    10'd1022, 10'd1012, 10'd983,  10'd936,  10'd872,  10'd795,  10'd707,  10'd611,
    10'd511,  10'd411,  10'd315,  10'd227,  10'd150,  10'd86,   10'd39,   10'd10,
    10'd0,    10'd10,   10'd39,   10'd86,   10'd150,  10'd227,  10'd315,  10'd411
  };

endpackage

// File: rtl/carrier_generator.sv
// Phase counter and sine lookup producing one registered carrier sample per advance,
// optionally inverted about midscale.
module carrier_generator
  import bpsk_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    advance,
  input  logic                    invert,
  output logic [SIGNAL_WIDTH-1:0] sample,
  output logic                    wrap
);

  localparam logic [SIGNAL_WIDTH:0] TwoAmp    = (SIGNAL_WIDTH + 1)'(2 * AMPLITUDE);
  localparam logic [PHASE_W-1:0]    LastPhase = PHASE_W'(WAVELENGTH - 1);

  // phase_q is the phase of the sample currently on the output
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    active_q, active_d;
  logic [SIGNAL_WIDTH-1:0] sample_q, sample_d;

  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    sample_d = sample_q;
    if (clear) begin
      phase_d  = '0;
      active_d = 1'b0;
      sample_d = SIGNAL_WIDTH'(AMPLITUDE);
    end else if (advance) begin
      phase_d  = (!active_q || phase_q == LastPhase) ? '0 : phase_q + 1'b1;
      active_d = 1'b1;
      if (invert) begin
        sample_d = SIGNAL_WIDTH'(TwoAmp - {1'b0, SHIFTED_SINE_TABLE[phase_d]});
      end else begin
        sample_d = SHIFTED_SINE_TABLE[phase_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      sample_q <= SIGNAL_WIDTH'(AMPLITUDE);
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;
  assign wrap   = active_q && (phase_q == LastPhase);

endmodule

// File: rtl/signal_modulator.sv
// BPSK transmitter: preamble of bit-0 symbols, then one carrier period per handshaked bit,
// bit 1 sent inverted about midscale.
module signal_modulator
  import bpsk_pkg::*;
#(
  parameter int unsigned PREAMBLE_SYMBOLS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stp,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [SIGNAL_WIDTH-1:0] sample,
  output logic                    sample_valid,
  output logic                    symbol_start,
  output logic                    busy
);

  localparam int unsigned       PreCntW = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  localparam logic [PreCntW-1:0] PreLast = PreCntW'(PREAMBLE_SYMBOLS - 1);

  tx_state_t          state_q, state_d;
  logic [PreCntW-1:0] pre_cnt_q, pre_cnt_d;
  logic               cur_bit_q, cur_bit_d;
  logic               hold_valid_q, hold_valid_d;
  logic               hold_bit_q, hold_bit_d;
  logic               symbol_start_q, symbol_start_d;
  logic               load;
  logic               wrap;

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    cur_bit_d      = cur_bit_q;
    hold_valid_d   = hold_valid_q;
    hold_bit_d     = hold_bit_q;
    load           = 1'b0;

    if (stp) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (PREAMBLE_SYMBOLS == 0) begin
              state_d = DATA;
              load    = 1'b1;
            end else begin
              state_d   = PREAMBLE;
              pre_cnt_d = '0;
              cur_bit_d = 1'b0;
            end
          end
        end
        PREAMBLE: begin
          if (wrap) begin
            if (pre_cnt_q == PreLast) begin
              if (hold_valid_q) begin
                state_d = DATA;
                load    = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (wrap) begin
            if (hold_valid_q) load    = 1'b1;
            else              state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      cur_bit_d    = hold_valid_q & hold_bit_q;
      hold_valid_d = 1'b0;
    end
    // A fresh transfer wins over the load so the register ends up full.
    if (bit_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_bit_d   = bit_in;
    end
    if (stp) hold_valid_d = 1'b0;

    symbol_start_d = (state_d == DATA) && ((state_q != DATA) || wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pre_cnt_q      <= '0;
      cur_bit_q      <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_bit_q     <= 1'b0;
      symbol_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      cur_bit_q      <= cur_bit_d;
      hold_valid_q   <= hold_valid_d;
      hold_bit_q     <= hold_bit_d;
      symbol_start_q <= symbol_start_d;
    end
  end

  carrier_generator u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d == IDLE),
    .advance (state_d != IDLE),
    .invert  ((state_d == DATA) && cur_bit_d),
    .sample  (sample),
    .wrap    (wrap)
  );

  assign bit_ready    = ~hold_valid_q;
  assign sample_valid = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign symbol_start = symbol_start_q;

endmodule

// File: tb/tb_signal_modulator.sv
// Scoreboard bench for signal_modulator: one instance with a 4-symbol preamble, one without.
module tb_signal_modulator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 0, stp4 = 0, bit4 = 0, valid4 = 0;
  logic       ready4, svalid4, sstart4, busy4;
  logic [9:0] sample4;
  logic       start0 = 0, stp0 = 0, bit0 = 0, valid0 = 0;
  logic       ready0, svalid0, sstart0, busy0;
  logic [9:0] sample0;

  signal_modulator #(.PREAMBLE_SYMBOLS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stp(stp4), .bit_in(bit4), .bit_valid(valid4),
    .bit_ready(ready4), .sample(sample4), .sample_valid(svalid4), .symbol_start(sstart4),
    .busy(busy4)
  );

  signal_modulator #(.PREAMBLE_SYMBOLS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stp(stp0), .bit_in(bit0), .bit_valid(valid0),
    .bit_ready(ready0), .sample(sample0), .sample_valid(svalid0), .symbol_start(sstart0),
    .busy(busy0)
  );

  int          total = 0, bad = 0;
  int          tbl[32];
  logic [10:0] exp4[$], exp0[$];   // {symbol_start, sample}
  bit          bits_q[$];
  int          busy_cnt4 = 0, busy_cnt0 = 0, sym_cnt4 = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_part(input int which, input bit b, input bit sym, input int count);
    int          v;
    logic [10:0] e;
    for (int k = 0; k < count; k++) begin
      v = b ? 1022 - tbl[k] : tbl[k];
      e = {sym && (k == 0), 10'(v)};
      if (which == 0) exp4.push_back(e);
      else            exp0.push_back(e);
    end
  endtask

  task automatic push_sym(input int which, input bit b, input bit sym);
    push_part(which, b, sym, 32);
  endtask

  task automatic score(input int which, input logic vld, input logic [9:0] s, input logic ss);
    logic [10:0] e;
    int          qs;
    total++;
    qs = (which == 0) ? exp4.size() : exp0.size();
    if (!vld) begin
      if (s !== 10'd511 || ss !== 1'b0) begin
        bad++;
        $display("FAIL idle%0d: got sample=%0d sym=%0b, want sample=511 sym=0", which, s, ss);
      end
    end else if (qs == 0) begin
      bad++;
      $display("FAIL extra%0d: got sample=%0d sym=%0b, want no sample", which, s, ss);
    end else begin
      if (which == 0) e = exp4.pop_front();
      else            e = exp0.pop_front();
      if ({ss, s} !== e) begin
        bad++;
        $display("FAIL sample%0d: got sample=%0d sym=%0b, want sample=%0d sym=%0b",
                 which, s, ss, e[9:0], e[10]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      score(0, svalid4, sample4, sstart4);
      score(1, svalid0, sample0, sstart0);
      if (busy4)   busy_cnt4++;
      if (busy0)   busy_cnt0++;
      if (sstart4) sym_cnt4++;
    end
  end

  task automatic wait_idle(input int which, input int want, input string name);
    int n = 0;
    while (((which == 0) ? busy4 : busy0) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, int'((which == 0) ? busy4 : busy0), 0);
    check({name, " cycles"}, (which == 0) ? busy_cnt4 : busy_cnt0, want);
    check({name, " leftover"}, (which == 0) ? exp4.size() : exp0.size(), 0);
  endtask

  // Starts u_dut4 and offers every bit in bits_q back-to-back with bit_valid held high.
  task automatic stream4();
    int n = bits_q.size();
    int got = 0;
    int guard = 0;
    bit xfer;
    @(negedge clk);
    busy_cnt4 = 0;
    sym_cnt4  = 0;
    start4 = 1;
    valid4 = 1;
    bit4   = bits_q[0];
    repeat (4) push_sym(0, 1'b0, 1'b0);
    while (got < n && guard < 40000) begin
      xfer = 0;
      if (ready4) begin
        push_sym(0, bit4, 1'b1);
        got++;
        xfer = 1;
      end
      @(negedge clk);
      guard++;
      start4 = 0;
      if (xfer) begin
        if (got < n) bit4 = bits_q[got];
        else         valid4 = 0;
      end
    end
    valid4 = 0;
    check("stream accepted", got, n);
    bits_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 32; k++)
      tbl[k] = int'(511.0 + 511.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 32.0));

    #3 rst_n = 0;
    #1;
    check("rst sample", sample4, 511);
    check("rst busy", busy4, 0);
    check("rst ready", ready4, 1);
    check("rst valid", svalid4, 0);
    check("rst sym", sstart4, 0);
    check("rst ready0", ready0, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Preamble then 0,1,0
    bits_q = {1'b0, 1'b1, 1'b0};
    stream4();
    wait_idle(0, 32 * 7, "dir010");
    check("dir010 pulses", sym_cnt4, 3);

    // stp with start from IDLE
    @(negedge clk);
    start4 = 1;
    stp4   = 1;
    @(negedge clk);
    start4 = 0;
    stp4   = 0;
    check("stp+start busy", busy4, 0);

    // Underrun after one bit, then a held bit waits for a new start
    bits_q = {1'b1};
    stream4();
    wait_idle(0, 32 * 5, "underrun");
    @(negedge clk);
    valid4 = 1;
    bit4   = 1;
    @(negedge clk);
    valid4 = 0;
    repeat (40) @(negedge clk);
    check("held no start busy", busy4, 0);
    check("held ready", ready4, 0);
    busy_cnt4 = 0;
    start4 = 1;
    repeat (4) push_sym(0, 1'b0, 1'b0);
    push_sym(0, 1'b1, 1'b1);
    @(negedge clk);
    start4 = 0;
    wait_idle(0, 32 * 5, "restart");

    // No preamble: bit 1 held, start
    @(negedge clk);
    valid0 = 1;
    bit0   = 1;
    @(negedge clk);
    valid0 = 0;
    busy_cnt0 = 0;
    start0 = 1;
    push_sym(1, 1'b1, 1'b1);
    @(negedge clk);
    start0 = 0;
    wait_idle(1, 32, "nopre");

    // stp at phase 5 of DATA with another bit held
    @(negedge clk);
    valid0 = 1;
    bit0   = 0;
    @(negedge clk);
    valid0 = 0;
    start0 = 1;
    push_part(1, 1'b0, 1'b1, 6);
    @(negedge clk);
    start0 = 0;
    valid0 = 1;
    bit0   = 1;
    @(negedge clk);
    valid0 = 0;
    check("stp held", ready0, 0);
    repeat (4) @(negedge clk);
    stp0 = 1;
    @(negedge clk);
    stp0 = 0;
    check("stp busy", busy0, 0);
    check("stp ready", ready0, 1);
    check("stp sample", sample0, 511);
    check("stp leftover", exp0.size(), 0);

    // Random back-to-back stream
    for (int i = 0; i < 1000; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    stream4();
    wait_idle(0, 32 * 1004, "stream");
    check("stream pulses", sym_cnt4, 1000);

    // Reset at phase 17 of DATA
    bits_q = {1'b1};
    stream4();
    repeat (145) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst sample", sample4, 511);
    check("midrst busy", busy4, 0);
    check("midrst ready", ready4, 1);
    check("midrst valid", svalid4, 0);
    check("midrst consumed", exp4.size(), 14);
    exp4.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
